// File: rtl/fifo_srl_almost_full_ctrl.sv
// rtl/fifo_srl_almost_full_ctrl.sv - almost-full shift-register FIFO with early producer back-pressure
//
// Purpose:
//   First-word-fall-through FIFO built on an addressable shift register.
//   New words enter at entry[0] and age toward higher addresses.
//   The oldest word sits at entry[count-1] and is driven straight onto if_dout.
//   if_full_n drops GRACE_PERIOD slots before the store is really full.
//   This lets a pipelined producer land writes that are already in flight.
//   Such writes are still accepted while space remains.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   if_write_ce  in   write-side clock enable
//   if_write     in   write request
//   if_din       in   write data [DATA_WIDTH]
//   if_full_n    out  registered; high = producer may issue writes
//   if_read_ce   in   read-side clock enable
//   if_read      in   read request (pop)
//   if_empty_n   out  registered; high = if_dout holds valid data
//   if_dout      out  oldest stored word [DATA_WIDTH], first-word-fall-through
//   overflow     out  sticky; set when a write is dropped at full with no pop

module fifo_srl_almost_full_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 16,
  parameter int GRACE_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic                  if_empty_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  overflow
);

  // Thresholds sized to the occupancy counter so every compare is width-matched.
  localparam int                THRESH       = DEPTH - GRACE_PERIOD;
  localparam logic [ADDR_WIDTH:0] DEPTH_C    = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] THRESH_C   = THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic [ADDR_WIDTH:0]   count_m1;
  logic [ADDR_WIDTH-1:0] raddr;

  logic wr_req;
  logic rd_req;
  logic pop;
  logic push;
  logic drop;

  // Request decode. A pop at full frees the slot the same cycle, so a
  // simultaneous push is legal there. The shift then discards the popped word.
  assign wr_req = if_write & if_write_ce;
  assign rd_req = if_read & if_read_ce;
  assign pop    = rd_req & (count != '0);
  assign push   = wr_req & ((count < DEPTH_C) | pop);
  assign drop   = wr_req & ~push;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Oldest word lives at count-1. Address 0 is used when empty, where the
  // output is don't-care anyway.
  assign count_m1 = count - 1'b1;
  assign raddr    = (count != '0) ? count_m1[ADDR_WIDTH-1:0] : '0;
  assign if_dout  = mem[raddr];

  // Storage carries no reset. After reset the stale contents are unreachable
  // because count returns to 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Flags are registered from count_next so they line up with the new count
  // on the same edge instead of lagging by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      count      <= count_next;
      if_empty_n <= (count_next != '0);
      if_full_n  <= (count_next < THRESH_C);
      overflow   <= overflow | drop;
    end
  end

endmodule

// File: tb/tb_fifo_srl_almost_full_ctrl.sv
// tb/tb_fifo_srl_almost_full_ctrl.sv - self-checking bench for fifo_srl_almost_full_ctrl
module tb_fifo_srl_almost_full_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int GRACE = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_read_ce;
  logic          if_read;
  logic          if_empty_n;
  logic [DW-1:0] if_dout;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue whose front is the oldest word.
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          model_valid = 1'b0;

  fifo_srl_almost_full_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .GRACE_PERIOD(GRACE)
  ) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read),
    .if_empty_n(if_empty_n), .if_dout(if_dout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      automatic bit wr = if_write && if_write_ce;
      automatic bit rd = if_read && if_read_ce;
      automatic bit pp = rd && (q.size() > 0);
      automatic bit ps = wr && ((q.size() < DEPTH) || pp);
      if (pp) void'(q.pop_front());
      if (ps) q.push_back(if_din);
      if (wr && !ps) m_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_empty_n", {31'd0, if_empty_n}, {31'd0, q.size() != 0});
      chk("model_full_n", {31'd0, if_full_n}, {31'd0, q.size() < DEPTH - GRACE});
      chk("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (q.size() != 0) chk("model_dout", if_dout, q[0]);
    end
  end

  task automatic tick(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic wce = 1'b1, input logic rce = 1'b1, input logic rst = 1'b0);
    if_write    = w;
    if_din      = d;
    if_read     = r;
    if_write_ce = wce;
    if_read_ce  = rce;
    reset       = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_write = 0; if_din = '0; if_read = 0;
    if_write_ce = 1; if_read_ce = 1; reset = 1;

    // Reset then fill
    tick(0, 0, 0, 1, 1, 1);
    tick(0, 0, 0, 1, 1, 1);
    chk("rst_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk("rst_full_n", {31'd0, if_full_n}, 32'd1);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 1; i <= 14; i++) begin
      tick(1, i, 0);
      chk("fill_empty_n", {31'd0, if_empty_n}, 32'd1);
      chk("fill_dout", if_dout, 32'd1);
      chk("fill_full_n", {31'd0, if_full_n}, (i < 14) ? 32'd1 : 32'd0);
    end

    // Grace slots and overflow
    tick(1, 15, 0);
    tick(1, 16, 0);
    chk("grace_full_n", {31'd0, if_full_n}, 32'd0);
    chk("grace_overflow", {31'd0, overflow}, 32'd0);
    tick(1, 17, 0);
    chk("drop_overflow", {31'd0, overflow}, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      chk("drain1_dout", if_dout, k);
      tick(0, 0, 1);
    end
    chk("drain1_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk("sticky_overflow", {31'd0, overflow}, 32'd1);

    // Push + pop at full
    tick(0, 0, 0, 1, 1, 1);
    for (int i = 1; i <= 16; i++) tick(1, i, 0);
    chk("full_overflow", {31'd0, overflow}, 32'd0);
    chk("full_dout_before", if_dout, 32'd1);
    tick(1, 99, 1);
    chk("full_pp_dout", if_dout, 32'd2);
    chk("full_pp_full_n", {31'd0, if_full_n}, 32'd0);
    chk("full_pp_overflow", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      chk("drain2_dout", if_dout, (k < 15) ? k + 2 : 99);
      tick(0, 0, 1);
    end
    chk("drain2_empty_n", {31'd0, if_empty_n}, 32'd0);

    // Empty boundary and write-CE masking
    tick(1, 7, 1);
    chk("empty_pp_empty_n", {31'd0, if_empty_n}, 32'd1);
    chk("empty_pp_dout", if_dout, 32'd7);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("empty_pop_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk("empty_pop_full_n", {31'd0, if_full_n}, 32'd1);
    chk("empty_pop_overflow", {31'd0, overflow}, 32'd0);
    tick(1, 42, 0, 0, 1);
    chk("wce_mask_empty_n", {31'd0, if_empty_n}, 32'd0);

    // Streaming at count 3, then read-CE masking
    for (int v = 0; v < 3; v++) tick(1, v, 0);
    for (int v = 3; v < 100; v++) begin
      chk("stream_dout", if_dout, v - 3);
      tick(1, v, 1);
      chk("stream_full_n", {31'd0, if_full_n}, 32'd1);
    end
    tick(1, 100, 1, 1, 0);
    tick(1, 101, 1, 1, 0);
    for (int v = 97; v <= 101; v++) begin
      chk("rce_drain_dout", if_dout, v);
      tick(0, 0, 1);
    end
    chk("rce_drain_empty_n", {31'd0, if_empty_n}, 32'd0);

    // Mid-operation reset at count 9 with overflow set
    for (int i = 0; i < 16; i++) tick(1, 300 + i, 0);
    tick(1, 999, 0);
    chk("mid_overflow_set", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) tick(0, 0, 1);
    tick(1, 400, 0);
    chk("mid_dout_before", if_dout, 32'd308);
    tick(1, 55, 1, 1, 1, 1);
    chk("mid_rst_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk("mid_rst_full_n", {31'd0, if_full_n}, 32'd1);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    tick(1, 5, 0);
    chk("post_rst_dout", if_dout, 32'd5);
    chk("post_rst_empty_n", {31'd0, if_empty_n}, 32'd1);
    tick(0, 0, 0);
    tick(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_srl_almost_full_ctrl.md
# fifo_srl_almost_full_ctrl

Complete almost-full FIFO built around an addressable shift-register store. This block is the control and read end of that store:
- It counts occupancy and converts push/pop handshakes into the shift-enable and read-address controls.
- It presents the oldest word to the consumer.
- It deasserts the producer's `if_full_n` a configurable number of slots early, so a pipelined producer can land in-flight writes.

It sits on every inter-PE stream in the SpMV datapath.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 4, read-address width; `DEPTH <= 2**ADDR_WIDTH`.
- `DEPTH`, 16, storage slots; legal range 2..2**ADDR_WIDTH.
- `GRACE_PERIOD`, 2, slots reserved after `if_full_n` drops; legal range 0..DEPTH-1.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_write_ce`  in  1  write-side clock enable.
- `if_write`  in  1  write request.
- `if_din`  in  DATA_WIDTH  write data.
- `if_full_n`  out  1  registered; high = producer may issue writes.
- `if_read_ce`  in  1  read-side clock enable.
- `if_read`  in  1  read request (pop).
- `if_empty_n`  out  1  registered; high = `if_dout` holds valid data.
- `if_dout`  out  DATA_WIDTH  oldest stored word, first-word-fall-through.
- `overflow`  out  1  sticky; set when a write is dropped.

## Operation
**Internal state**
- `count`, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Storage is a DEPTH-entry shift register: on shift, entry[i+1] <= entry[i] and entry[0] <= `if_din`.

**Request decode**
- `wr_req = if_write & if_write_ce`.
- `rd_req = if_read & if_read_ce`.
- `pop = rd_req & (count != 0)`.
- `push = wr_req & ((count < DEPTH) | pop)`.
- Push is accepted regardless of `if_full_n`. The grace slots exist for writes issued after `if_full_n` falls.

**Dropped writes**
- A write with `wr_req & ~push` is a write at count==DEPTH with no pop. It is discarded and sets `overflow`.
- `overflow` clears only on `reset`.

**Storage and count update**
- Shift enable equals `push`; nothing else shifts storage.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - both, or neither: unchanged.
- Read address = count-1 when count != 0, else 0.
- `if_dout` = entry[read address], combinational from registered state. At count==0 it is don't-care and must not be checked.

**Simultaneous push and pop**
- count > 0: the oldest word leaves as the shift moves the next-oldest into address count-1. Count is unchanged.
- count == DEPTH: the shift discards the word being popped. Legal, no overflow.
- count == 0: the pop is ignored and the push proceeds.

**Flags** (registered, computed from next-count)
- `if_empty_n` = (count_next != 0).
- `if_full_n` = (count_next < DEPTH-GRACE_PERIOD).

**Reset**
- `reset` forces count=0, `if_empty_n`=0, `if_full_n`=1, `overflow`=0.
- Storage contents are not cleared.
- Reset wins over any same-cycle push or pop. Mid-operation reset discards all stored words.

## Timing
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on `if_dout`, with `if_empty_n`=1, after edge N.
- Pop takes effect at the edge where `pop` is sampled. The next word is on `if_dout` immediately after that edge.
- `if_full_n` falls after the edge that makes count reach DEPTH-GRACE_PERIOD. It rises after the edge that takes count below that value.
- With GRACE_PERIOD=0, `if_full_n` is the true full flag.
- Sustained push+pop every cycle at any nonzero count gives throughput of 1 word/cycle, with count constant.
- `if_write_ce`=0 or `if_read_ce`=0 masks the respective request entirely, with no side effects.
- All outputs change only on `clk` rising edges, except `if_dout`, which follows registered state through the storage address mux.

## Test plan
- **Reset then fill:** reset; push 1..14 on consecutive cycles (DEPTH=16, GRACE=2).
  - `if_full_n` goes 0 after the 14th push edge.
  - `if_empty_n`=1 after the first push.
  - `if_dout`=1 throughout.
- **Grace and overflow:** continue pushing 15, 16 with `if_full_n`=0.
  - Both are accepted; count=16 and `overflow`=0.
  - Push 17 is dropped and `overflow`=1 (sticky).
  - Pop 16 times yields 1..16 in order; `if_empty_n`=0 after the last pop.
- **Full push+pop:** at count=16 holding 1..16, push 99 with a simultaneous pop.
  - `if_dout` was 1 and becomes 2; count stays 16; `overflow` stays 0.
  - Draining yields 2..16, 99.
- **Empty boundary:** at count=0, assert `if_read` with push 7.
  - Next cycle count=1 and `if_dout`=7.
  - A pop alone at count=0 changes nothing.
- **Streaming and CE masking:** push+pop every cycle of values 0..99 with count held at 3.
  - Output order is exact and `if_full_n` stays 1.
  - Drop `if_read_ce` for 2 cycles while `if_read`=1: count rises by 2 and no words are lost.
- **Mid-operation reset:** at count=9, assert `reset` together with push and pop.
  - Next cycle count=0, `if_empty_n`=0, `if_full_n`=1, `overflow`=0.
  - Push 5: `if_dout`=5 next cycle.
